// File: rtl/issue_queue_2picker.sv
// In-order issue queue: single enqueue port, two in-order dequeue ports.
// out0 presents the oldest entry, out1 the second-oldest; out1 pops only alongside out0.
module issue_queue_2picker #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             sys_clk,
  input  logic             sys_rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  input  logic             out0_ready,
  input  logic             out1_ready,
  output logic             in_ready,
  output logic             out0_valid,
  output logic [WIDTH-1:0] out0_data,
  output logic             out1_valid,
  output logic [WIDTH-1:0] out1_data
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_head;
  logic [PW-1:0]    r_tail;
  logic [CW-1:0]    r_count;

  logic             w_push;
  logic             w_fire0;
  logic             w_fire1;
  logic [1:0]       w_pops;
  logic [PW-1:0]    w_head1;
  logic [PW-1:0]    w_head_nxt;
  logic [PW-1:0]    w_tail_nxt;
  logic [CW-1:0]    w_count_nxt;

  // Pointer increment with explicit wrap so DEPTH need not be a power of two.
  function automatic logic [PW-1:0] f_inc(input logic [PW-1:0] p);
    if (p == PW'(DEPTH - 1)) begin
      f_inc = '0;
    end else begin
      f_inc = p + PW'(1);
    end
  endfunction

  assign in_ready   = (r_count < CW'(DEPTH));
  assign out0_valid = (r_count >= CW'(1));
  assign out1_valid = (r_count >= CW'(2));
  assign w_head1    = f_inc(r_head);
  assign out0_data  = out0_valid ? r_mem[r_head]  : '0;
  assign out1_data  = out1_valid ? r_mem[w_head1] : '0;

  assign w_push  = in_valid & in_ready;
  assign w_fire0 = out0_valid & out0_ready;
  assign w_fire1 = w_fire0 & out1_valid & out1_ready;
  assign w_pops  = {1'b0, w_fire0} + {1'b0, w_fire1};

  always_comb begin
    w_head_nxt = r_head;
    case (w_pops)
      2'd0:    w_head_nxt = r_head;
      2'd1:    w_head_nxt = w_head1;
      2'd2:    w_head_nxt = f_inc(w_head1);
      default: w_head_nxt = r_head;
    endcase
  end

  always_comb begin
    w_tail_nxt = r_tail;
    if (w_push) begin
      w_tail_nxt = f_inc(r_tail);
    end else begin
      w_tail_nxt = r_tail;
    end
  end

  assign w_count_nxt = r_count + CW'(w_push) - CW'(w_pops);

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      r_head  <= w_head_nxt;
      r_tail  <= w_tail_nxt;
      r_count <= w_count_nxt;
    end
  end

  // Payload storage is not reset; validity is tracked solely by r_count.
  always_ff @(posedge sys_clk) begin
    if (w_push) begin
      r_mem[r_tail] <= in_data;
    end
  end

endmodule

// File: tb/tb_issue_queue_2picker.sv
// Self-checking bench for issue_queue_2picker: directed scenarios plus
// randomized traffic checked every cycle against a queue-based model.
module tb_issue_queue_2picker;

  localparam int WIDTH = 8;
  localparam int DEPTH = 4;

  logic             sys_clk;
  logic             sys_rst;
  logic             in_valid;
  logic [WIDTH-1:0] in_data;
  logic             out0_ready;
  logic             out1_ready;
  logic             in_ready;
  logic             out0_valid;
  logic [WIDTH-1:0] out0_data;
  logic             out1_valid;
  logic [WIDTH-1:0] out1_data;

  int n_checks;
  int n_fail;
  bit chk_en;
  logic [WIDTH-1:0] q[$];

  issue_queue_2picker #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .sys_clk    (sys_clk),
    .sys_rst    (sys_rst),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .out0_ready (out0_ready),
    .out1_ready (out1_ready),
    .in_ready   (in_ready),
    .out0_valid (out0_valid),
    .out0_data  (out0_data),
    .out1_valid (out1_valid),
    .out1_data  (out1_data)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: queue contents after applying the rules at one clock edge.
  task automatic model_edge();
    int sz;
    bit push, f0, f1;
    sz = q.size();
    if (sys_rst) begin
      q.delete();
    end else begin
      push = in_valid && (sz < DEPTH);
      f0   = (sz >= 1) && out0_ready;
      f1   = f0 && (sz >= 2) && out1_ready;
      if (f0) void'(q.pop_front());
      if (f1) void'(q.pop_front());
      if (push) q.push_back(in_data);
    end
  endtask

  // Per-cycle comparison of every output against the model.
  always @(negedge sys_clk) begin
    if (chk_en) begin
      chk("in_ready",   32'(in_ready),   32'(q.size() < DEPTH));
      chk("out0_valid", 32'(out0_valid), 32'(q.size() >= 1));
      chk("out1_valid", 32'(out1_valid), 32'(q.size() >= 2));
      chk("out0_data",  32'(out0_data),  (q.size() >= 1) ? 32'(q[0]) : 32'd0);
      chk("out1_data",  32'(out1_data),  (q.size() >= 2) ? 32'(q[1]) : 32'd0);
    end
  end

  task automatic step(input logic v, input logic [WIDTH-1:0] d, input logic r0, input logic r1);
    in_valid   = v;
    in_data    = d;
    out0_ready = r0;
    out1_ready = r1;
    @(posedge sys_clk);
    model_edge();
    #1;
  endtask

  initial begin
    int phase;
    n_checks   = 0;
    n_fail     = 0;
    chk_en     = 1'b0;
    sys_rst    = 1'b1;
    in_valid   = 1'b0;
    in_data    = 8'h00;
    out0_ready = 1'b0;
    out1_ready = 1'b0;
    #2;
    chk("rst_in_ready",   32'(in_ready),   32'd1);
    chk("rst_out0_valid", 32'(out0_valid), 32'd0);
    chk("rst_out1_valid", 32'(out1_valid), 32'd0);
    chk("rst_out0_data",  32'(out0_data),  32'd0);
    chk("rst_out1_data",  32'(out1_data),  32'd0);
    @(posedge sys_clk);
    #1;
    sys_rst = 1'b0;
    chk_en  = 1'b1;

    // Fill to full, then a rejected push.
    step(1'b1, 8'h11, 1'b0, 1'b0);
    step(1'b1, 8'h22, 1'b0, 1'b0);
    step(1'b1, 8'h33, 1'b0, 1'b0);
    step(1'b1, 8'h44, 1'b0, 1'b0);
    chk("t1_full_in_ready", 32'(in_ready), 32'd0);
    chk("t1_out0", 32'(out0_data), 32'h11);
    chk("t1_out1", 32'(out1_data), 32'h22);
    step(1'b1, 8'h55, 1'b0, 1'b0);
    chk("t1_still_out0", 32'(out0_data), 32'h11);
    chk("t1_qsize", 32'(q.size()), 32'd4);

    // Dual pop from full.
    step(1'b0, 8'h00, 1'b1, 1'b1);
    chk("t2_out0", 32'(out0_data), 32'h33);
    chk("t2_out1", 32'(out1_data), 32'h44);
    chk("t2_in_ready", 32'(in_ready), 32'd1);

    // Push with dual pop in the same cycle.
    step(1'b1, 8'h66, 1'b1, 1'b1);
    chk("t3_out0", 32'(out0_data), 32'h66);
    chk("t3_out1_valid", 32'(out1_valid), 32'd0);

    // out1_ready alone does nothing; out0_ready alone pops one.
    step(1'b1, 8'hA1, 1'b1, 1'b0);
    step(1'b1, 8'hB2, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b1);
    chk("t4_hold_out0", 32'(out0_data), 32'hA1);
    chk("t4_hold_out1", 32'(out1_data), 32'hB2);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    chk("t4_single_out0", 32'(out0_data), 32'hB2);
    chk("t4_single_out1v", 32'(out1_valid), 32'd0);

    // No bypass into an empty queue.
    step(1'b0, 8'h00, 1'b1, 1'b0);
    in_valid = 1'b1; in_data = 8'hC3; out0_ready = 1'b1; out1_ready = 1'b1;
    chk("t5_empty_out0v", 32'(out0_valid), 32'd0);
    step(1'b1, 8'hC3, 1'b1, 1'b1);
    chk("t5_next_out0v", 32'(out0_valid), 32'd1);
    chk("t5_next_out0",  32'(out0_data),  32'hC3);

    // Randomized traffic alternating fill-heavy and drain-heavy phases.
    for (int c = 0; c < 3000; c++) begin
      phase = (c / 37) % 3;
      step(($urandom_range(0, 9) < ((phase == 0) ? 9 : (phase == 1) ? 2 : 5)) ? 1'b1 : 1'b0,
           8'($urandom),
           ($urandom_range(0, 9) < ((phase == 0) ? 2 : (phase == 1) ? 9 : 5)) ? 1'b1 : 1'b0,
           1'($urandom));
    end
    for (int c = 0; c < DEPTH; c++) step(1'b0, 8'h00, 1'b1, 1'b1);
    chk("t6_drained_out0v", 32'(out0_valid), 32'd0);
    chk("t6_drained_out1v", 32'(out1_valid), 32'd0);

    // Asynchronous reset mid-stream.
    step(1'b1, 8'hD4, 1'b0, 1'b0);
    step(1'b1, 8'hE5, 1'b0, 1'b0);
    chk("t6_pre_rst_out1v", 32'(out1_valid), 32'd1);
    in_valid = 1'b0; out0_ready = 1'b0; out1_ready = 1'b0;
    #2;
    sys_rst = 1'b1;
    q.delete();
    #1;
    chk("t6_rst_out0v", 32'(out0_valid), 32'd0);
    chk("t6_rst_out1v", 32'(out1_valid), 32'd0);
    chk("t6_rst_in_ready", 32'(in_ready), 32'd1);
    step(1'b0, 8'h00, 1'b0, 1'b0);
    sys_rst = 1'b0;
    step(1'b1, 8'h5A, 1'b0, 1'b0);
    chk("t6_post_rst_out0", 32'(out0_data), 32'h5A);
    step(1'b0, 8'h00, 1'b0, 1'b0);

    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
